// File: rtl/fsk_pkg.sv
// Shared constants and the frame-packing helper for the FSK modulator datapath.
// The serializer and any future pin-side blocks agree on frame layout through this package.
package fsk_pkg;

  localparam int FRAME_W    = 32;
  localparam int SAMPLE_W   = 13;
  localparam int BIT_CYCLES = 2;

  localparam logic [1:0] I_SYNC = 2'b10;
  localparam logic [1:0] Q_SYNC = 2'b01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ser_state_t;

  // Layout MSB first: I sync, I13, pad, Q sync, Q13, pad.
  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic [SAMPLE_W-1:0] i13,
    input logic [SAMPLE_W-1:0] q13
  );
    return {I_SYNC, i13, 1'b0, Q_SYNC, q13, 1'b0};
  endfunction

endpackage

// File: rtl/iq_serializer_if.sv
// Valid/ready sample-pair handshake between the FSK modulator and the serializer.
interface iq_serializer_if #(
  parameter int IN_W = 13
) ();

  logic [IN_W-1:0] in_i;
  logic [IN_W-1:0] in_q;
  logic            in_valid;
  logic            in_ready;

  modport master (
    output in_i,
    output in_q,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_i,
    input  in_q,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/iq_serializer.sv
// Packs one I/Q pair per 32-bit frame and shifts it out MSB first, two clocks per bit,
// with a self-generated bit clock that rises mid-bit. One-entry holding buffer, no bypass.
module iq_serializer
  import fsk_pkg::*;
#(
  parameter int IN_W = 13
) (
  input  logic             top_clk,
  input  logic             top_rst,
  input  logic             enable,
  iq_serializer_if.slave   in_bus,
  output logic             serial_iq,
  output logic             serial_clk,
  output logic             frame_start,
  output logic             underrun
);

  localparam logic [4:0] LAST_BIT = 5'(FRAME_W - 1);

  ser_state_t          state_reg, state_next;
  logic [FRAME_W-1:0]  frame_reg, frame_next;
  logic [4:0]          bit_cnt_reg, bit_cnt_next;
  logic                phase_reg, phase_next;
  logic                frame_start_reg, frame_start_next;
  logic                underrun_reg, underrun_next;
  logic                buf_full_reg, buf_full_next;
  logic [SAMPLE_W-1:0] buf_i_reg, buf_i_next;
  logic [SAMPLE_W-1:0] buf_q_reg, buf_q_next;
  logic                in_ready_reg;

  logic signed [IN_W-1:0] in_i_s;
  logic signed [IN_W-1:0] in_q_s;
  logic [SAMPLE_W-1:0]    in_i_ext;
  logic [SAMPLE_W-1:0]    in_q_ext;
  logic                   transfer;
  logic                   load;

  assign in_i_s   = in_bus.in_i;
  assign in_q_s   = in_bus.in_q;
  assign in_i_ext = SAMPLE_W'(in_i_s);
  assign in_q_ext = SAMPLE_W'(in_q_s);

  assign transfer = in_bus.in_valid && !buf_full_reg;

  always_comb begin
    state_next       = state_reg;
    frame_next       = frame_reg;
    bit_cnt_next     = bit_cnt_reg;
    phase_next       = phase_reg;
    frame_start_next = 1'b0;
    underrun_next    = underrun_reg;
    buf_full_next    = buf_full_reg;
    buf_i_next       = buf_i_reg;
    buf_q_next       = buf_q_reg;
    load             = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        phase_next = 1'b0;
        frame_next = '0;
        if (enable) begin
          load = 1'b1;
        end
      end
      ST_RUN: begin
        if (!phase_reg) begin
          phase_next = 1'b1;
        end else if (bit_cnt_reg == 5'd0) begin
          if (enable) begin
            load = 1'b1;
          end else begin
            state_next = ST_IDLE;
            frame_next = '0;
            phase_next = 1'b0;
          end
        end else begin
          phase_next   = 1'b0;
          bit_cnt_next = bit_cnt_reg - 5'd1;
          frame_next   = {frame_reg[FRAME_W-2:0], 1'b0};
        end
      end
      default: begin
        state_next = ST_IDLE;
        frame_next = '0;
        phase_next = 1'b0;
      end
    endcase

    if (transfer) begin
      buf_full_next = 1'b1;
      buf_i_next    = in_i_ext;
      buf_q_next    = in_q_ext;
    end

    // A load with an empty buffer sends zeros; a pair arriving in that same
    // cycle stays in the buffer for the following frame.
    if (load) begin
      state_next       = ST_RUN;
      bit_cnt_next     = LAST_BIT;
      phase_next       = 1'b0;
      frame_start_next = 1'b1;
      if (buf_full_reg) begin
        frame_next    = pack_frame(buf_i_reg, buf_q_reg);
        buf_full_next = 1'b0;
      end else begin
        frame_next    = pack_frame('0, '0);
        underrun_next = 1'b1;
      end
    end
  end

  always_ff @(posedge top_clk or posedge top_rst) begin
    if (top_rst) begin
      state_reg       <= ST_IDLE;
      frame_reg       <= '0;
      bit_cnt_reg     <= '0;
      phase_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
      underrun_reg    <= 1'b0;
      buf_full_reg    <= 1'b0;
      buf_i_reg       <= '0;
      buf_q_reg       <= '0;
      in_ready_reg    <= 1'b1;
    end else begin
      state_reg       <= state_next;
      frame_reg       <= frame_next;
      bit_cnt_reg     <= bit_cnt_next;
      phase_reg       <= phase_next;
      frame_start_reg <= frame_start_next;
      underrun_reg    <= underrun_next;
      buf_full_reg    <= buf_full_next;
      buf_i_reg       <= buf_i_next;
      buf_q_reg       <= buf_q_next;
      in_ready_reg    <= !buf_full_next;
    end
  end

  assign serial_iq       = frame_reg[FRAME_W-1];
  assign serial_clk      = phase_reg;
  assign frame_start     = frame_start_reg;
  assign underrun        = underrun_reg;
  assign in_bus.in_ready = in_ready_reg;

endmodule

// File: tb/tb_iq_serializer.sv
// Randomized bench for iq_serializer: a cycle-level monitor predicts every output from
// frame timing rules and a queue model of the holding buffer; an IN_W=8 instance covers sign extension.
module tb_iq_serializer;

  logic clk;
  logic rst;
  logic enable;
  logic serial_iq, serial_clk, frame_start, underrun;
  logic en8;
  logic s8_iq, s8_clk, s8_fs, s8_ur;
  logic rdy_last;
  int   n_checks;
  int   n_pass;

  iq_serializer_if #(.IN_W(13)) bus ();
  iq_serializer_if #(.IN_W(8))  bus8 ();

  iq_serializer #(.IN_W(13)) dut (
    .top_clk     (clk),
    .top_rst     (rst),
    .enable      (enable),
    .in_bus      (bus),
    .serial_iq   (serial_iq),
    .serial_clk  (serial_clk),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  iq_serializer #(.IN_W(8)) dut8 (
    .top_clk     (clk),
    .top_rst     (rst),
    .enable      (en8),
    .in_bus      (bus8),
    .serial_iq   (s8_iq),
    .serial_clk  (s8_clk),
    .frame_start (s8_fs),
    .underrun    (s8_ur)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] frame_of(input logic [12:0] i13, input logic [12:0] q13);
    return {2'b10, i13, 1'b0, 2'b01, q13, 1'b0};
  endfunction

  // Reference model: frames last 64 cycles, a frame starts whenever enable is
  // seen in idle or at the end of a frame, and takes the oldest buffered pair.
  initial begin : monitor
    bit          busy;
    int          cnt;
    logic [31:0] exp_word;
    logic [25:0] mq[$];
    logic [25:0] p;
    logic        m_under;
    logic        m_ready;
    logic        load_exp;
    busy = 0; cnt = 0; exp_word = '0; m_under = 0; m_ready = 1;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        busy = 0; cnt = 0; mq.delete(); m_under = 0; m_ready = 1;
      end else begin
        if (busy) cnt++;
        load_exp = enable && (!busy || cnt == 64);
        if (busy && cnt == 64 && !enable) busy = 0;
        check("frame_start", frame_start, load_exp);
        if (load_exp) begin
          if (mq.size() > 0) begin
            p = mq.pop_front();
            exp_word = frame_of(p[25:13], p[12:0]);
          end else begin
            exp_word = frame_of(13'd0, 13'd0);
            m_under = 1;
          end
          busy = 1;
          cnt = 0;
        end
        if (bus.in_valid && m_ready) mq.push_back({bus.in_i, bus.in_q});
        m_ready = (mq.size() == 0);
        check("in_ready", bus.in_ready, m_ready);
        check("underrun", underrun, m_under);
        if (busy) begin
          check("serial_clk", serial_clk, cnt % 2);
          check("serial_iq", serial_iq, exp_word[31 - cnt / 2]);
        end else begin
          check("idle_clk", serial_clk, 0);
          check("idle_iq", serial_iq, 0);
        end
      end
    end
  end

  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!frame_start && n < 200);
    check(tag, frame_start, 1);
  endtask

  // One negedge of streaming: retire an accepted pair, maybe offer a new one.
  task automatic drive_cycle(input bit allow_new);
    @(negedge clk);
    if (bus.in_valid && rdy_last) bus.in_valid = 1'b0;
    if (allow_new && !bus.in_valid && bus.in_ready && $urandom_range(0, 3) == 0) begin
      bus.in_i     = 13'($urandom);
      bus.in_q     = 13'($urandom);
      bus.in_valid = 1'b1;
      $display("stream pair i=%h q=%h", bus.in_i, bus.in_q);
    end
    rdy_last = bus.in_ready;
  endtask

  initial begin
    logic [31:0] w13, w8, ref13, ref8;
    n_checks = 0; n_pass = 0;
    rst = 0; enable = 0; en8 = 0; rdy_last = 1;
    bus.in_valid = 0; bus.in_i = '0; bus.in_q = '0;
    bus8.in_valid = 0; bus8.in_i = '0; bus8.in_q = '0;

    #2 rst = 1;
    #1;
    check("rst_iq", serial_iq, 0);
    check("rst_clk", serial_clk, 0);
    check("rst_fs", frame_start, 0);
    check("rst_under", underrun, 0);
    check("rst_ready", bus.in_ready, 1);
    repeat (3) @(negedge clk);
    rst = 0;

    // Single frame on both instances, enable pulsed for one cycle.
    @(negedge clk);
    bus.in_i = 13'h0A5; bus.in_q = 13'h1FFF; bus.in_valid = 1;
    bus8.in_i = 8'h80;  bus8.in_q = 8'h7F;   bus8.in_valid = 1;
    @(negedge clk);
    bus.in_valid = 0; bus8.in_valid = 0;
    enable = 1; en8 = 1;
    @(negedge clk);
    enable = 0; en8 = 0;
    w13 = '0; w8 = '0;
    for (int b = 0; b < 32; b++) begin
      @(posedge clk); #2;
      w13 = {w13[30:0], serial_iq};
      w8  = {w8[30:0], s8_iq};
      check("clk8_high", s8_clk, 1);
      @(posedge clk);
    end
    ref13 = 32'b10_0000010100101_0_01_1111111111111_0;
    ref8  = {2'b10, 13'h1F80, 1'b0, 2'b01, 13'h007F, 1'b0};
    check("single_word", w13, ref13);
    check("signext_word", w8, ref8);
    check("signext_under", s8_ur, 0);
    $display("single frame word=%h signext word=%h", w13, w8);

    // Streaming: preload, then 4 frames with enable dropped during bit 16 of the 4th.
    repeat (4) @(negedge clk);
    @(negedge clk);
    bus.in_i = 13'($urandom); bus.in_q = 13'($urandom); bus.in_valid = 1;
    @(negedge clk);
    bus.in_valid = 0;
    enable = 1;
    rdy_last = bus.in_ready;
    for (int n = 1; n <= 223; n++) drive_cycle(n < 200);
    enable = 0;
    for (int n = 0; n < 50; n++) drive_cycle(0);
    check("stream_under", underrun, 0);
    $display("streaming done");

    // Underrun: first frame drains the buffer, second has nothing to send.
    @(negedge clk);
    enable = 1;
    wait_fs("fs_A");
    wait_fs("fs_B");
    check("underrun_set", underrun, 1);
    repeat (5) @(negedge clk);
    bus.in_i = 13'($urandom); bus.in_q = 13'($urandom); bus.in_valid = 1;
    $display("late pair i=%h q=%h", bus.in_i, bus.in_q);
    @(negedge clk);
    bus.in_valid = 0;
    wait_fs("fs_C");
    // Present a pair exactly at the next load edge.
    repeat (63) @(negedge clk);
    @(negedge clk);
    bus.in_i = 13'($urandom); bus.in_q = 13'($urandom); bus.in_valid = 1;
    $display("load-cycle pair i=%h q=%h", bus.in_i, bus.in_q);
    @(negedge clk);
    bus.in_valid = 0;
    wait_fs("fs_E");

    // Asynchronous reset mid-frame.
    repeat (20) @(negedge clk);
    #2 rst = 1;
    #1;
    check("mid_rst_iq", serial_iq, 0);
    check("mid_rst_clk", serial_clk, 0);
    check("mid_rst_fs", frame_start, 0);
    check("mid_rst_under", underrun, 0);
    check("mid_rst_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #2;
    check("fs_after_rst", frame_start, 1);
    $display("reset mid-frame done");
    repeat (10) @(negedge clk);
    enable = 0;
    repeat (80) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/iq_serializer.md
# iq_serializer

Serializes the modulator's I/Q baseband samples into the framed, bit-serial format driven onto the `serial_iq` / `serial_clk` pins toward the RF transceiver. It sits directly downstream of the FSK modulator and consumes one I/Q sample pair per 32-bit frame. The modulator-facing side is a valid/ready handshake. The pin side is a self-clocked serial stream, two `top_clk` cycles per bit.

## Interface
- `IN_W`, 13: input sample width in bits, 2..13; sign-extended to 13 bits internally.
- `top_clk`  in  1  system clock; all logic on its rising edge.
- `top_rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  level; 1 = stream frames, 0 = stop after the current frame.
- `in_i`  in  IN_W  signed I sample.
- `in_q`  in  IN_W  signed Q sample.
- `in_valid`  in  1  sample pair present.
- `in_ready`  out  1  holding buffer can accept a pair.
- `serial_iq`  out  1  serial data, MSB first.
- `serial_clk`  out  1  bit clock; rises in the middle of each bit.
- `frame_start`  out  1  one-cycle pulse in the cycle bit 31 of a frame is first driven.
- `underrun`  out  1  sticky; set when a frame loads with the buffer empty.

## Operation
- **Frame word, 32 bits, MSB first:**
  - [31:30] = 2'b10 (I sync)
  - [29:17] = I13
  - [16] = 0
  - [15:14] = 2'b01 (Q sync)
  - [13:1] = Q13
  - [0] = 0
- **Holding buffer:** 1 entry. `in_ready` = buffer empty. A transfer occurs when `in_valid` && `in_ready`.
- **FSM states:**
  - IDLE: `serial_iq` = 0, `serial_clk` = 0. On an edge with `enable` = 1, go to RUN and load a frame.
  - RUN: 5-bit bit counter (31 down to 0) plus 1-bit phase.
    - phase 0: `serial_clk` = 0; phase 1: `serial_clk` = 1.
    - Shift to the next bit when phase 1 goes to 0.
    - After bit 0 phase 1: if `enable` = 1, load the next frame; otherwise return to IDLE.
- **Frame load:**
  - Buffer full: the frame takes the buffer contents and the buffer empties.
  - Buffer empty: the frame is sent with I = Q = 0 (sync bits intact), and `underrun` is set.
  - A pair presented in the load cycle while the buffer is empty is captured into the buffer for the *next* frame. There is no bypass.
- **`enable` falling mid-frame:** the current frame completes in full and is never truncated. Buffer contents are retained across IDLE.
- **Clearing `underrun`:** only by `top_rst`.

## Timing
- **Reset values:** state IDLE, `serial_iq` 0, `serial_clk` 0, `frame_start` 0, `underrun` 0, `in_ready` 1, buffer empty. All outputs are registered.
- **Frame length:** 64 `top_clk` cycles. Back-to-back frames have no gap.
- **Start latency:** `enable` sampled 1 in IDLE at edge t. Then `serial_iq` = bit 31 and `frame_start` = 1 from edge t, and `serial_clk` rises at edge t+1.
- **Bit timing:** each bit is stable for 2 cycles and changes only while `serial_clk` goes low. A receiver sampling on the `serial_clk` rising edge has one full cycle of setup and hold.
- **Handshake timing:**
  - `in_ready` falls the cycle after a transfer.
  - `in_ready` rises the cycle after the load that drains the buffer.
  - Maximum sustained rate: 1 pair per 64 cycles.
- **Reset mid-frame:** immediate asynchronous return to the reset values. A partial frame is abandoned.

## Structure
- **Shared package (`fsk_pkg`):** `FRAME_W` = 32, `SAMPLE_W` = 13, `I_SYNC` = 2'b10, `Q_SYNC` = 2'b01, `BIT_CYCLES` = 2, and the frame-packing function (I13, Q13 → 32-bit word).
- **Sub-modules:** none; the block is a single module. The holding buffer is inline logic, not a separate FIFO instance.

## Test plan
- **Reset:** assert `top_rst` mid-frame → all outputs return to the reset values asynchronously. After release with `enable` = 1, a fresh frame starts with `frame_start`.
- **Single frame:** load I = 0x0A5, Q = −1 (`IN_W` = 13), then pulse `enable` for 1 cycle → serial bits are `10 0000010100101 0 01 1111111111111 0`, each held 2 cycles, and `serial_clk` toggles every cycle for 64 cycles, then stays low.
- **Sign extension:** `IN_W` = 8, I = 8'h80, Q = 8'h7F → I field 13'h1F80, Q field 13'h007F.
- **Streaming:** provide a new pair each time `in_ready` = 1, with `enable` held for 4 frames → 4 contiguous frames, `frame_start` every 64 cycles, `underrun` stays 0.
- **Underrun:** `enable` = 1 with no samples supplied → the frame carries zeros in both data fields and `underrun` = 1 from the load cycle. A later sample is sent in the following frame.
- **Simultaneous events:** with the buffer empty, `in_valid` in the load cycle → the current frame is zeros with `underrun` set, and the next frame carries that sample. `enable` dropped at bit 16 → the frame completes, then IDLE.
